receive_chk_pipe: RTL and testbench

- Parametrised successor to the single-word receive checker.
- Each input word carries a packed-BCD payload plus a binary check field. The block registers the word, converts the payload from BCD to binary, and compares the result against the check field.
- Adds a valid/ready handshake, a 2-stage pipeline with backpressure, a frame-lock state machine and a saturating error counter.
- Sits between the link deserialiser and the downstream consumer.

---
 rtl/receive_chk_pipe_pkg.sv | 22 ++
 rtl/receive_bcd2bin.sv | 28 ++
 rtl/receive_chk_pipe.sv | 159 +++++++++++++++
 tb/tb_receive_chk_pipe.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/receive_chk_pipe_pkg.sv
// Shared constants for the receive checker: BCD digit limit, frame-lock states,
// and the check-field width needed for a given number of BCD digits.
package receive_chk_pipe_pkg;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // Bits required to hold 10^digits-1; 10^digits is never a power of two.
  function automatic int chk_width(input int digits);
    int pow10;
    pow10 = 1;
    for (int i = 0; i < digits; i++) begin
      pow10 = pow10 * 10;
    end
    return $clog2(pow10);
  endfunction

endpackage

// File: rtl/receive_bcd2bin.sv
// Combinational packed-BCD to binary converter with a per-digit validity flag.
// The result is accumulated most-significant digit first at CHK_W bits.
module receive_bcd2bin
  import receive_chk_pipe_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int CHK_W  = 7
) (
  input  logic [4*DIGITS-1:0] payload,
  output logic [CHK_W-1:0]    bin,
  output logic                bcd_ok
);

  logic [3:0] digit_s;

  // Horner evaluation: bin = bin*10 + digit, flag any nibble above nine.
  always_comb begin
    bin     = {CHK_W{1'b0}};
    bcd_ok  = 1'b1;
    digit_s = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      digit_s = payload[4*i +: 4];
      bin     = CHK_W'(bin * CHK_W'(10)) + CHK_W'(digit_s);
      bcd_ok  = bcd_ok & (digit_s <= BCD_DIGIT_MAX);
    end
  end

endmodule

// File: rtl/receive_chk_pipe.sv
// Two-stage valid/ready receive checker: BCD payload vs binary check field,
// frame-lock FSM and saturating error counter (counter built under RECEIVE_ERR_CNT_EN).
module receive_chk_pipe
  import receive_chk_pipe_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int CHK_W    = 7,
  parameter int SYNC_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHK_W+4*DIGITS-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [4*DIGITS-1:0]       out_data,
  output logic                      out_ok,
  output logic                      lock,
  output logic [CNT_W-1:0]          err_cnt
);

  localparam int PW      = 4 * DIGITS;
  localparam int MAX_RUN = (SYNC_CNT > LOSS_CNT) ? SYNC_CNT : LOSS_CNT;
  localparam int RUN_W   = $clog2(MAX_RUN + 1);

  logic                  adv_s;
  logic                  hs_s;
  logic                  s1_valid_r;
  logic [CHK_W+PW-1:0]   s1_data_r;
  logic [PW-1:0]         s1_payload_s;
  logic [CHK_W-1:0]      s1_check_s;
  logic [CHK_W-1:0]      bin_s;
  logic                  bcd_ok_s;
  logic                  ok_s;
  lock_state_t           state_r;
  lock_state_t           state_nxt_s;
  logic [RUN_W-1:0]      run_r;
  logic [RUN_W-1:0]      run_nxt_s;
  logic [RUN_W-1:0]      run_inc_s;

  // Both stages share one stall: the pipe moves whenever the output slot frees up.
  assign adv_s        = !out_valid || out_ready;
  assign in_ready     = adv_s;
  assign hs_s         = out_valid && out_ready;
  assign s1_payload_s = s1_data_r[PW-1:0];
  assign s1_check_s   = s1_data_r[PW +: CHK_W];
  assign ok_s         = bcd_ok_s && (bin_s == s1_check_s);
  assign run_inc_s    = run_r + RUN_W'(1);

  receive_bcd2bin #(
    .DIGITS (DIGITS),
    .CHK_W  (CHK_W)
  ) u_bcd2bin (
    .payload (s1_payload_s),
    .bin     (bin_s),
    .bcd_ok  (bcd_ok_s)
  );

  // Stage 1: capture the incoming word; a bubble only clears the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {(CHK_W+PW){1'b0}};
    end else if (adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_data_r <= in_data;
      end
    end
  end

  // Stage 2: output slot holding payload and check verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= {PW{1'b0}};
      out_ok    <= 1'b0;
    end else if (adv_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_data <= s1_payload_s;
        out_ok   <= ok_s;
      end
    end
  end

  // Frame-lock next state: counts consecutive good (HUNT) or bad (LOCKED) handshakes.
  always_comb begin
    state_nxt_s = state_r;
    run_nxt_s   = run_r;
    if (hs_s) begin
      case (state_r)
        HUNT: begin
          if (out_ok) begin
            if (run_inc_s >= RUN_W'(SYNC_CNT)) begin
              state_nxt_s = LOCKED;
              run_nxt_s   = {RUN_W{1'b0}};
            end else begin
              run_nxt_s = run_inc_s;
            end
          end else begin
            run_nxt_s = {RUN_W{1'b0}};
          end
        end
        LOCKED: begin
          if (!out_ok) begin
            if (run_inc_s >= RUN_W'(LOSS_CNT)) begin
              state_nxt_s = HUNT;
              run_nxt_s   = {RUN_W{1'b0}};
            end else begin
              run_nxt_s = run_inc_s;
            end
          end else begin
            run_nxt_s = {RUN_W{1'b0}};
          end
        end
        default: begin
          state_nxt_s = HUNT;
          run_nxt_s   = {RUN_W{1'b0}};
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      run_nxt_s   = run_r;
    end
  end

  // FSM state, run counter and lock flag; lock tracks the state on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= HUNT;
      run_r   <= {RUN_W{1'b0}};
      lock    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      run_r   <= run_nxt_s;
      lock    <= (state_nxt_s == LOCKED);
    end
  end

`ifdef RECEIVE_ERR_CNT_EN
  localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

  // Bad-word counter, saturating rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= {CNT_W{1'b0}};
    end else if (hs_s && !out_ok && (err_cnt != ERR_MAX)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`else
  assign err_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_receive_chk_pipe.sv
// Directed bench for receive_chk_pipe; err_cnt expectations follow RECEIVE_ERR_CNT_EN.
// A second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_receive_chk_pipe;

`ifdef RECEIVE_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_ok;
  logic        lock;
  logic [7:0]  err_cnt;

  logic        sat_in_ready;
  logic        sat_out_valid;
  logic [7:0]  sat_out_data;
  logic        sat_out_ok;
  logic        sat_lock;
  logic [1:0]  sat_err_cnt;

  int checks = 0;
  int errors = 0;

  receive_chk_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ok(out_ok),
    .lock(lock), .err_cnt(err_cnt)
  );

  receive_chk_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data), .out_ok(sat_out_ok),
    .lock(sat_lock), .err_cnt(sat_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated word: present, bubble, check output, then check post-handshake state.
  task automatic word(input string tag, input logic [14:0] d, input logic exp_ok,
                      input logic exp_lock, input logic [7:0] exp_err);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    check({tag, "_lat1"}, out_valid, 1'b0);
    in_valid = 1'b0;
    tick();
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, d[7:0]);
    check({tag, "_ok"}, out_ok, exp_ok);
    tick();
    check({tag, "_drain"}, out_valid, 1'b0);
    check({tag, "_lock"}, lock, exp_lock);
    check({tag, "_err"}, err_cnt, ERR_EN ? exp_err : 8'd0);
  endtask

  logic [14:0] stream [10];
  logic [7:0]  held;
  logic        stall_prev;
  logic        acc;
  int          idx;
  int          oidx;
  int          cyc;

  initial begin
    stream[0] = 15'h0C12; stream[1] = 15'h2234; stream[2] = 15'h3856; stream[3] = 15'h4E78;
    stream[4] = 15'h5A90; stream[5] = 15'h0101; stream[6] = 15'h1723; stream[7] = 15'h2D45;
    stream[8] = 15'h4367; stream[9] = 15'h5989;

    rst_n = 1'b0; in_valid = 1'b0; in_data = 15'h0000; out_ready = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_ok", out_ok, 1'b0);
    check("rst_lock", lock, 1'b0);
    check("rst_err", err_cnt, 8'd0);
    check("rst_in_ready", in_ready, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_valid", out_valid, 1'b0);

    // Check/lock sequence; run and error count values hand-tracked.
    word("good42",  15'h2A42, 1'b1, 1'b0, 8'd0);
    word("badchk",  15'h2B42, 1'b0, 1'b0, 8'd1);
    word("badbcd",  15'h2A4A, 1'b0, 1'b0, 8'd2);
    check("sat_err_2", sat_err_cnt, ERR_EN ? 2'd2 : 2'd0);
    word("good99",  15'h6399, 1'b1, 1'b0, 8'd2);
    word("good00",  15'h0000, 1'b1, 1'b0, 8'd2);
    word("good07",  15'h0707, 1'b1, 1'b0, 8'd2);
    word("good10",  15'h0A10, 1'b1, 1'b1, 8'd2);
    word("lbad1",   15'h0B10, 1'b0, 1'b1, 8'd3);
    word("lbadF0",  15'h00F0, 1'b0, 1'b1, 8'd4);
    word("lgood55", 15'h3755, 1'b1, 1'b1, 8'd4);
    word("loss1",   15'h0001, 1'b0, 1'b1, 8'd5);
    word("loss2",   15'h0001, 1'b0, 1'b1, 8'd6);
    word("loss3",   15'h0001, 1'b0, 1'b0, 8'd7);
    check("sat_err_stick", sat_err_cnt, ERR_EN ? 2'd3 : 2'd0);

    // Backpressure stream: out_ready pattern 1,0,0 repeating.
    idx = 0; oidx = 0; cyc = 0; stall_prev = 1'b0; held = 8'h00;
    while (oidx < 10 && cyc < 200) begin
      if (stall_prev) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", out_data, held);
      end
      out_ready = ((cyc % 3) == 0);
      in_valid  = (idx < 10);
      in_data   = (idx < 10) ? stream[idx] : 15'h0000;
      #1;
      check("in_ready", in_ready, !(out_valid && !out_ready));
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        check("stream_data", out_data, stream[oidx][7:0]);
        check("stream_ok", out_ok, 1'b1);
        oidx++;
      end
      stall_prev = out_valid && !out_ready;
      held = out_data;
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    check("stream_count", oidx, 10);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("stream_drain", out_valid, 1'b0);
    check("stream_lock", lock, 1'b1);
    check("stream_err", err_cnt, ERR_EN ? 8'd7 : 8'd0);

    // Asynchronous reset in the middle of a stream.
    in_valid = 1'b1;
    in_data = 15'h0C12;
    tick();
    tick();
    tick();
    check("pre_rst_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_lock", lock, 1'b0);
    check("mid_rst_err", err_cnt, 8'd0);
    check("mid_rst_sat_err", sat_err_cnt, 2'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("post_rst_valid", out_valid, 1'b0);
    check("post_rst_ready", in_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
